// File: rtl/ssram_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port write-first RAM.
// An optional post-reset sweep writes INIT_VALUE to every word before traffic is accepted.
module ssram_port_arbiter #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 10,
    parameter bit                    INIT_CLEAR = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_di,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  init_done
);

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic                    init_last;
    logic                    last_gnt;
    logic                    rsp_pend;
    logic                    rsp_id;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata1_q;

    assign init_last = (init_cnt == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) state <= INIT_CLEAR ? INIT : RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == INIT && init_last) state_next = RUN;
    end

    always_comb begin
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (!rst) begin
            case (state)
                INIT: begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = init_cnt;
                    ram_di   = INIT_VALUE;
                end
                RUN: begin
                    // Contention goes to whichever master did not win last time.
                    m0_gnt = m0_req && (!m1_req || last_gnt);
                    m1_gnt = m1_req && (!m0_req || !last_gnt);
                    if (m0_gnt) begin
                        ram_en   = 1'b1;
                        ram_we   = m0_we;
                        ram_addr = m0_addr;
                        ram_di   = m0_wdata;
                    end else if (m1_gnt) begin
                        ram_en   = 1'b1;
                        ram_we   = m1_we;
                        ram_addr = m1_addr;
                        ram_di   = m1_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt  <= '0;
            last_gnt  <= 1'b1;
            rsp_pend  <= 1'b0;
            rsp_id    <= 1'b0;
            init_done <= !INIT_CLEAR;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
            if (state == INIT && init_last) init_done <= 1'b1;
            rsp_pend <= (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
            rsp_id   <= m1_gnt;
            if (m0_gnt || m1_gnt) last_gnt <= m1_gnt;
            if (m0_rvalid) rdata0_q <= ram_dout;
            if (m1_rvalid) rdata1_q <= ram_dout;
        end
    end

    // Read data is passed straight through on the response cycle and held afterwards.
    assign m0_rvalid = !rst && rsp_pend && !rsp_id;
    assign m1_rvalid = !rst && rsp_pend &&  rsp_id;
    assign m0_rdata  = m0_rvalid ? ram_dout : rdata0_q;
    assign m1_rdata  = m1_rvalid ? ram_dout : rdata1_q;

endmodule

// File: tb/tb_ssram_port_arbiter.sv
// Bench for ssram_port_arbiter: RAM model, directed scenarios, random traffic vs a transaction-level model.
module tb_ssram_port_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req [2];
    logic          we  [2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wdata[2];

    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ram_en, ram_we, init_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di, ram_dout;

    logic          b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid;
    logic [DW-1:0] b_m0_rdata, b_m1_rdata;
    logic          b_ram_en, b_ram_we, b_init_done;
    logic [AW-1:0] b_ram_addr;
    logic [DW-1:0] b_ram_di;
    logic [DW-1:0] b_ram_dout = '0;

    ssram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_CLEAR(1'b1), .INIT_VALUE('0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_dout(ram_dout), .init_done(init_done)
    );

    ssram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_CLEAR(1'b0), .INIT_VALUE('0)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_di(b_ram_di),
        .ram_dout(b_ram_dout), .init_done(b_init_done)
    );

    // Single-port write-first RAM macro.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_di;
                ram_dout          <= ram_di;
            end else begin
                ram_dout <= ram_mem[ram_addr];
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    // Transaction-level expectation: sweep progress, round-robin memory, contents, outstanding read.
    bit            exp_sweeping;
    int            exp_sweep_idx;
    bit            exp_done;
    int            exp_last;
    logic [DW-1:0] exp_mem [DEPTH];
    bit            exp_pend;
    int            exp_pend_id;
    logic [DW-1:0] exp_pend_data;
    logic [DW-1:0] exp_hold [2];
    int            granted;
    bit            check_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_sweeping  = 1'b1;
        exp_sweep_idx = 0;
        exp_done      = 1'b0;
        exp_last      = 1;
        exp_pend      = 1'b0;
        exp_hold[0]   = '0;
        exp_hold[1]   = '0;
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge, return 1ns later.
    task automatic tick();
        int g;
        bit rv0, rv1;
        @(negedge clk);
        g = -1;
        if (!rst && !exp_sweeping) begin
            if (req[0] && req[1]) g = (exp_last == 0) ? 1 : 0;
            else if (req[0])      g = 0;
            else if (req[1])      g = 1;
        end
        rv0 = !rst && exp_pend && exp_pend_id == 0;
        rv1 = !rst && exp_pend && exp_pend_id == 1;
        chk("m0_gnt", 32'(m0_gnt), 32'(g == 0));
        chk("m1_gnt", 32'(m1_gnt), 32'(g == 1));
        chk("m0_rvalid", 32'(m0_rvalid), 32'(rv0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(rv1));
        if (!rst) begin
            chk("init_done", 32'(init_done), 32'(exp_done));
            chk("m0_rdata", 32'(m0_rdata), 32'(rv0 ? exp_pend_data : exp_hold[0]));
            chk("m1_rdata", 32'(m1_rdata), 32'(rv1 ? exp_pend_data : exp_hold[1]));
        end
        if (rst) begin
            chk("ram_en_rst", 32'(ram_en), 32'd0);
        end else if (exp_sweeping) begin
            chk("sweep_en", 32'(ram_en), 32'd1);
            chk("sweep_we", 32'(ram_we), 32'd1);
            chk("sweep_addr", 32'(ram_addr), 32'(exp_sweep_idx));
            chk("sweep_di", 32'(ram_di), 32'd0);
        end else begin
            chk("ram_en", 32'(ram_en), 32'(g >= 0));
            if (g >= 0) begin
                chk("ram_we", 32'(ram_we), 32'(we[g]));
                chk("ram_addr", 32'(ram_addr), 32'(addr[g]));
                if (we[g]) chk("ram_di", 32'(ram_di), 32'(wdata[g]));
            end
        end
        if (check_b) begin
            chk("b_init_done", 32'(b_init_done), 32'd1);
            chk("b_m0_gnt", 32'(b_m0_gnt), 32'(req[0]));
            check_b = 1'b0;
        end
        @(posedge clk);
        granted = g;
        if (rst) begin
            model_reset();
        end else begin
            if (rv0) exp_hold[0] = exp_pend_data;
            if (rv1) exp_hold[1] = exp_pend_data;
            exp_pend = 1'b0;
            if (exp_sweeping) begin
                exp_mem[exp_sweep_idx] = '0;
                if (exp_sweep_idx == DEPTH - 1) begin
                    exp_sweeping = 1'b0;
                    exp_done     = 1'b1;
                end
                exp_sweep_idx++;
            end else if (g >= 0) begin
                exp_last = g;
                if (we[g]) begin
                    exp_mem[addr[g]] = wdata[g];
                end else begin
                    exp_pend      = 1'b1;
                    exp_pend_id   = g;
                    exp_pend_data = exp_mem[addr[g]];
                end
            end
        end
        #1;
    endtask

    task automatic drive(input int k, input bit r, input bit w, input int a, input int d);
        req[k]   = r;
        we[k]    = w;
        addr[k]  = AW'(a);
        wdata[k] = DW'(d);
    endtask

    initial begin
        drive(0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check_b = 1'b0;
        granted = -1;
        model_reset();
        @(posedge clk); #1;

        // Reset held two edges with m0 requesting; then the sweep, then m0 granted.
        tick();
        tick();
        rst     = 1'b0;
        check_b = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        drive(0, 0, 0, 0, 0);
        tick();

        // Write then read of the same word from different masters.
        drive(0, 1, 1, 'h012, 'hBEEF);
        tick();
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 0, 'h012, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        chk("t2_rdata", 32'(m1_rdata), 32'hBEEF);
        tick();

        // Continuous contention: reads alternate.
        drive(0, 1, 0, 'h012, 0);
        drive(1, 1, 0, 'h013, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t3_alternate", 32'(granted), 32'(i % 2));
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();

        // m1 streams reads back to back.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, i, 0);
            tick();
            chk("t4_stream", 32'(granted), 32'd1);
        end
        drive(1, 0, 0, 0, 0);
        tick();
        tick();

        // Random traffic on a small address window; requests are held until granted or withdrawn.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(req[k] && granted != k && $urandom_range(7) != 0))
                    drive(k, $urandom_range(3) != 0, $urandom_range(1), $urandom_range(15),
                          $urandom_range(16'hFFFF));
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();
        tick();

        // Reset right after a read grant squashes the response and restarts the sweep.
        drive(0, 1, 0, 5, 0);
        tick();
        chk("t5_granted", 32'(granted), 32'd0);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        for (int c = 0; c < 100; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(req[k] && granted != k))
                    drive(k, $urandom_range(1), $urandom_range(1), $urandom_range(7),
                          $urandom_range(16'hFFFF));
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
